// File: rtl/chan_mux_scan.sv
// Channel multiplexer with manual select and timed auto-scan (dwell + blanking).
// All outputs are registered; dout follows the channel selected one cycle earlier.
module chan_mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 100000,
  parameter int BLANK    = 4,
  localparam int SEL_W   = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS),
  localparam int PRESC_W = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      load_sel,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          sel_out,
  output logic [CHANNELS-1:0]       chan_en,
  output logic                      tick
);

  typedef enum logic [1:0] {MANUAL, DWELL_ST, BLANK_ST} state_t;

  state_t               state_reg, state_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [WIDTH-1:0]     dout_reg, dout_next;
  logic [CHANNELS-1:0]  chan_en_reg, chan_en_next, onehot_next;
  logic                 tick_reg, tick_next;
  logic                 load_ok;
  logic                 advance;

  // Pad the channel table to a power of two so unused select codes read zero.
  logic [WIDTH-1:0] chan_arr [2**SEL_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2**SEL_W; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_used
        assign chan_arr[gi] = din[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan_arr[gi] = '0;
      end
    end
    for (gi = 0; gi < CHANNELS; gi++) begin : g_onehot
      assign onehot_next[gi] = (sel_next == SEL_W'(gi));
    end
  endgenerate

  assign load_ok = load_sel && (32'(sel_in) < CHANNELS);

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    presc_next = presc_reg;
    advance    = 1'b0;

    case (state_reg)
      MANUAL: begin
        presc_next = '0;
        if (mode) state_next = DWELL_ST;
      end
      DWELL_ST: begin
        if (presc_reg == PRESC_W'(DWELL - 1)) begin
          advance    = 1'b1;
          presc_next = '0;
          state_next = (BLANK > 0) ? BLANK_ST : DWELL_ST;
        end else begin
          presc_next = presc_reg + PRESC_W'(1);
        end
      end
      BLANK_ST: begin
        // The prescaler doubles as the blanking counter; BLANK < DWELL keeps it in range.
        if (presc_reg == PRESC_W'(BLANK - 1)) begin
          presc_next = '0;
          state_next = DWELL_ST;
        end else begin
          presc_next = presc_reg + PRESC_W'(1);
        end
      end
      default: begin
        presc_next = '0;
        state_next = MANUAL;
      end
    endcase

    if (!mode) begin
      state_next = MANUAL;
      presc_next = '0;
      advance    = 1'b0;
    end

    // A valid load beats a coincident terminal count and restarts the dwell.
    if (load_ok) begin
      sel_next   = sel_in;
      presc_next = '0;
      advance    = 1'b0;
      if (mode) state_next = DWELL_ST;
    end

    if (advance) begin
      sel_next = (sel_reg == SEL_W'(CHANNELS - 1)) ? '0 : sel_reg + SEL_W'(1);
    end

    tick_next    = advance;
    chan_en_next = (state_next == BLANK_ST) ? '0 : onehot_next;
    dout_next    = chan_arr[sel_reg];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= MANUAL;
      sel_reg     <= '0;
      presc_reg   <= '0;
      dout_reg    <= '0;
      chan_en_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      presc_reg   <= presc_next;
      dout_reg    <= dout_next;
      chan_en_reg <= chan_en_next;
      tick_reg    <= tick_next;
    end
  end

  assign dout    = dout_reg;
  assign sel_out = sel_reg;
  assign chan_en = chan_en_reg;
  assign tick    = tick_reg;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench: main instance (4 ch, DWELL=8, BLANK=2), a 3-channel instance
// for out-of-range loads and a BLANK=0 instance for back-to-back dwells.
module tb_chan_mux_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        mode;
  logic [1:0]  sel_in;
  logic        load_sel;

  logic [3:0] dout, chan_en;
  logic [1:0] sel_out;
  logic       tick;

  logic [3:0] dout3;
  logic [2:0] chan_en3;
  logic [1:0] sel_out3;
  logic       tick3;

  logic [3:0] dout0, chan_en0;
  logic [1:0] sel_out0;
  logic       tick0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chan_mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(8), .BLANK(2)) dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .sel_in(sel_in),
    .load_sel(load_sel), .dout(dout), .sel_out(sel_out), .chan_en(chan_en), .tick(tick));

  chan_mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(8), .BLANK(2)) dut3 (
    .clk(clk), .reset(reset), .din(din[11:0]), .mode(mode), .sel_in(sel_in),
    .load_sel(load_sel), .dout(dout3), .sel_out(sel_out3), .chan_en(chan_en3), .tick(tick3));

  chan_mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(8), .BLANK(0)) dut0 (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .sel_in(sel_in),
    .load_sel(load_sel), .dout(dout0), .sel_out(sel_out0), .chan_en(chan_en0), .tick(tick0));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_tick, n_en, n_zero;
  logic [7:0] seq;

  initial begin
    reset = 1'b1; mode = 1'b0; load_sel = 1'b0; sel_in = 2'd0; din = 16'hD2A5;
    step(); step();
    check_eq("rst_sel", 32'(sel_out), 32'd0);
    check_eq("rst_chan_en", 32'(chan_en), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);

    reset = 1'b0;
    step();
    check_eq("post_rst_chan_en", 32'(chan_en), 32'b0001);
    check_eq("post_rst_dout", 32'(dout), 32'h5);

    sel_in = 2'd2; load_sel = 1'b1;
    step();
    load_sel = 1'b0;
    check_eq("man_sel", 32'(sel_out), 32'd2);
    step();
    check_eq("man_dout", 32'(dout), 32'h2);
    check_eq("man_chan_en", 32'(chan_en), 32'b0100);

    // sel_in=3 is illegal for the 3-channel instance but legal for the main one
    sel_in = 2'd3; load_sel = 1'b1;
    step();
    load_sel = 1'b0;
    check_eq("oor_sel3", 32'(sel_out3), 32'd2);
    check_eq("oor_dout3", 32'(dout3), 32'h2);
    check_eq("oor_dout3_known", 32'($isunknown(dout3)), 32'd0);
    check_eq("main_sel3", 32'(sel_out), 32'd3);

    mode = 1'b1;
    step();
    check_eq("scan_entry_chan_en", 32'(chan_en), 32'b1000);
    n_tick = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      n_tick += int'(tick);
    end
    check_eq("dwell_no_early_tick", 32'(n_tick), 32'd0);
    step();
    check_eq("adv_tick", 32'(tick), 32'd1);
    check_eq("adv_sel", 32'(sel_out), 32'd0);
    check_eq("blank1_chan_en", 32'(chan_en), 32'd0);
    step();
    check_eq("blank2_chan_en", 32'(chan_en), 32'd0);
    check_eq("blank2_tick", 32'(tick), 32'd0);
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (chan_en == 4'b0001) n_en++;
    end
    check_eq("dwell_ch0_cycles", 32'(n_en), 32'd8);
    step();
    check_eq("adv2_tick", 32'(tick), 32'd1);
    check_eq("adv2_sel", 32'(sel_out), 32'd1);

    // Collision: load on the terminal-count cycle of channel 1's dwell
    step(); step();
    check_eq("dwell_ch1_chan_en", 32'(chan_en), 32'b0010);
    for (int i = 0; i < 7; i++) step();
    sel_in = 2'd1; load_sel = 1'b1;
    step();
    load_sel = 1'b0;
    check_eq("coll_no_tick", 32'(tick), 32'd0);
    check_eq("coll_sel", 32'(sel_out), 32'd1);
    check_eq("coll_chan_en", 32'(chan_en), 32'b0010);
    n_tick = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      n_tick += int'(tick);
    end
    check_eq("coll_full_dwell", 32'(n_tick), 32'd0);
    step();
    check_eq("coll_tick", 32'(tick), 32'd1);
    check_eq("coll_adv_sel", 32'(sel_out), 32'd2);

    // Now in blanking: reset must override it
    reset = 1'b1;
    step();
    check_eq("rstblank_dout", 32'(dout), 32'd0);
    check_eq("rstblank_chan_en", 32'(chan_en), 32'd0);
    check_eq("rstblank_sel", 32'(sel_out), 32'd0);
    reset = 1'b0; mode = 1'b0;
    step();
    check_eq("rstblank_release_chan_en", 32'(chan_en), 32'b0001);

    // BLANK=0 instance: 32 cycles of scan
    mode = 1'b1;
    step();
    n_tick = 0; n_zero = 0; seq = 8'h00;
    for (int i = 0; i < 32; i++) begin
      step();
      if (tick0) begin
        n_tick++;
        seq = {seq[5:0], sel_out0};
      end
      if (chan_en0 == 4'b0000) n_zero++;
    end
    check_eq("b0_ticks", 32'(n_tick), 32'd4);
    check_eq("b0_sel_seq", 32'(seq), 32'b01_10_11_00);
    check_eq("b0_never_zero", 32'(n_zero), 32'd0);
    check_eq("b0_final_chan_en", 32'(chan_en0), 32'b0001);

    mode = 1'b0;
    step();
    check_eq("b0_manual_sel_kept", 32'(sel_out0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
